// File: rtl/beam_pcm_serializer.sv
// Purpose: round/shift/saturate a beam sum to PCM, buffer it, and stream it as a left-justified I2S-style frame.
// Latency: an accepted word can be popped the next cycle; its MSB is on sd from the IDLE-exit or frame-boundary cycle.
// Backpressure: in_ready drops when the FIFO is full (registered occupancy only); when no word is ready a zero frame is sent.
module beam_pcm_serializer #(
    parameter int IN_W       = 23,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 7,
    parameter int FIFO_DEPTH = 4,
    parameter int BCLK_DIV   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_W-1:0]               sum_in,
    input  logic                          sum_valid,
    output logic                          in_ready,
    input  logic                          en,
    input  logic                          sat_clr,
    output logic                          sclk,
    output logic                          ws,
    output logic                          sd,
    output logic                          sat_flag,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [DW-1:0]        DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0]        BIT_LAST = BW'(OUT_W - 1);
    localparam logic [LW-1:0]        LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic signed [IN_W:0] RND      = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] PCM_MAX  = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] PCM_MIN  = ~PCM_MAX;

    typedef enum logic [1:0] {IDLE, SLOT_L, SLOT_R} state_t;

    // conversion
    logic signed [IN_W:0] v_rnd;
    logic signed [IN_W:0] v_sh;
    logic [OUT_W-1:0]     pcm;
    logic                 clamp;

    // fifo
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic             push;
    logic             pop;
    logic             empty;

    // serializer
    state_t           state, state_nx;
    logic [BW-1:0]    bit_cnt, bit_cnt_nx;
    logic [OUT_W-1:0] shreg, shreg_nx;
    logic [DW-1:0]    div_cnt;
    logic             sclk_q;
    logic             bit_tick;
    logic             under_set;

    assign in_ready   = (level != LVL_FULL);
    assign empty      = (level == '0);
    assign push       = sum_valid & in_ready;
    assign fifo_level = level;
    assign bit_tick   = (state != IDLE) && (div_cnt == DIV_LAST) && sclk_q;

    assign sclk = sclk_q;
    assign ws   = (state == SLOT_R);
    assign sd   = (state == SLOT_L) & shreg[OUT_W-1];

    // Round half-up, arithmetic shift, then clamp into the signed PCM range.
    always_comb begin
        v_rnd = $signed({sum_in[IN_W-1], sum_in}) + RND;
        v_sh  = v_rnd >>> SHIFT;
        clamp = 1'b0;
        pcm   = v_sh[OUT_W-1:0];
        if (v_sh > PCM_MAX) begin
            clamp = 1'b1;
            pcm   = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (v_sh < PCM_MIN) begin
            clamp = 1'b1;
            pcm   = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    // Word storage; pointers alone define validity so the array needs no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pcm;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Bit clock divider: free-runs whenever a frame is active, parked low in IDLE.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            div_cnt <= '0;
            sclk_q  <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sclk_q  <= ~sclk_q;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Serializer state and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            shreg   <= shreg_nx;
        end
    end

    // Frame sequencing: en is only honoured at a frame boundary.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        pop        = 1'b0;
        under_set  = 1'b0;
        case (state)
            IDLE: begin
                if (en && !empty) begin
                    pop        = 1'b1;
                    shreg_nx   = mem[rd_ptr];
                    bit_cnt_nx = BIT_LAST;
                    state_nx   = SLOT_L;
                end
            end
            SLOT_L: begin
                if (bit_tick) begin
                    if (bit_cnt == '0) begin
                        bit_cnt_nx = BIT_LAST;
                        state_nx   = SLOT_R;
                    end else begin
                        shreg_nx   = shreg << 1;
                        bit_cnt_nx = bit_cnt - 1'b1;
                    end
                end
            end
            SLOT_R: begin
                if (bit_tick) begin
                    if (bit_cnt == '0) begin
                        bit_cnt_nx = BIT_LAST;
                        if (!en) begin
                            state_nx = IDLE;
                        end else if (!empty) begin
                            pop      = 1'b1;
                            shreg_nx = mem[rd_ptr];
                            state_nx = SLOT_L;
                        end else begin
                            under_set = 1'b1;
                            shreg_nx  = '0;
                            state_nx  = SLOT_L;
                        end
                    end else begin
                        bit_cnt_nx = bit_cnt - 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Sticky status; a set event in the same cycle as sat_clr takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (push && clamp) sat_flag <= 1'b1;
            else if (sat_clr)  sat_flag <= 1'b0;
            if (under_set)     underrun <= 1'b1;
            else if (sat_clr)  underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_beam_pcm_serializer.sv
module tb_beam_pcm_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [22:0] sum_in = '0;
    logic        sum_valid = 1'b0;
    logic        in_ready;
    logic        en = 1'b0;
    logic        sat_clr = 1'b0;
    logic        sclk, ws, sd, sat_flag, underrun;
    logic [2:0]  fifo_level;

    beam_pcm_serializer dut (
        .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid),
        .in_ready(in_ready), .en(en), .sat_clr(sat_clr), .sclk(sclk),
        .ws(ws), .sd(sd), .sat_flag(sat_flag), .underrun(underrun),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int glitches = 0;
    logic sd_p = 1'b0;
    logic ws_p = 1'b0;

    logic sd_bits [64];
    logic ws_bits [64];
    int   rise_cyc [64];

    typedef struct {
        logic [22:0] sum;
        logic [15:0] word;
        logic        sat;
    } vec_t;
    vec_t vecs [11];

    always @(posedge clk) cyc <= cyc + 1;

    // sd/ws must never move while sclk is high or as it rises
    always @(negedge clk) begin
        if (!rst && sclk === 1'b1 && (sd !== sd_p || ws !== ws_p)) glitches++;
        sd_p = sd;
        ws_p = ws;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Record sd/ws at each sclk rising edge, n bits into slots start..start+n-1.
    task automatic capture_bits(input int n, input int start);
        logic prev;
        int   wait_cnt;
        prev = sclk;
        for (int i = 0; i < n; i++) begin
            wait_cnt = 0;
            forever begin
                @(negedge clk);
                wait_cnt++;
                if (sclk && !prev) begin
                    prev = sclk;
                    break;
                end
                prev = sclk;
                if (wait_cnt > 40) break;
            end
            if (wait_cnt > 40) begin
                checks++;
                failures++;
                $display("FAIL capture_timeout actual=no_sclk_rise expected=rise bit=%0d", start + i);
                return;
            end
            sd_bits[start+i]  = sd;
            ws_bits[start+i]  = ws;
            rise_cyc[start+i] = cyc;
        end
    endtask

    function automatic logic [31:0] frame_sd(input int base);
        logic [31:0] f = '0;
        for (int i = 0; i < 32; i++) f = {f[30:0], sd_bits[base+i]};
        return f;
    endfunction

    function automatic logic [31:0] frame_ws(input int base);
        logic [31:0] f = '0;
        for (int i = 0; i < 32; i++) f = {f[30:0], ws_bits[base+i]};
        return f;
    endfunction

    task automatic push(input logic [22:0] v);
        sum_in    = v;
        sum_valid = 1'b1;
        @(negedge clk);
        sum_valid = 1'b0;
    endtask

    task automatic count_rises(input int ncyc, output int rises);
        logic prev;
        prev  = sclk;
        rises = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (sclk && !prev) rises++;
            prev = sclk;
        end
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        repeat (ncyc) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_sclk"}, 32'(sclk), 32'd0);
        chk({tag, "_ws"}, 32'(ws), 32'd0);
        chk({tag, "_sd"}, 32'(sd), 32'd0);
        chk({tag, "_level"}, 32'(fifo_level), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_sat_flag"}, 32'(sat_flag), 32'd0);
        chk({tag, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    initial begin
        int accepted;
        int rises;

        vecs[0]  = '{23'h000040, 16'h0001, 1'b0};
        vecs[1]  = '{23'h00003F, 16'h0000, 1'b0};
        vecs[2]  = '{23'h3FFFFF, 16'h7FFF, 1'b1};
        vecs[3]  = '{23'h400000, 16'h8000, 1'b0};
        vecs[4]  = '{23'h7FFFC0, 16'h0000, 1'b0};
        vecs[5]  = '{23'h7FFFBF, 16'hFFFF, 1'b0};
        vecs[6]  = '{23'h000000, 16'h0000, 1'b0};
        vecs[7]  = '{23'h3FFFBF, 16'h7FFF, 1'b0};
        vecs[8]  = '{23'h3FFFC0, 16'h7FFF, 1'b1};
        vecs[9]  = '{23'h123456, 16'h2469, 1'b0};
        vecs[10] = '{23'h5A5A5A, 16'hB4B5, 1'b0};

        @(negedge clk);
        do_reset(2);
        chk_reset_state("rst0");

        // conversion table: one single-frame burst per vector
        for (int k = 0; k < 11; k++) begin
            en      = 1'b0;
            sat_clr = 1'b1;
            @(negedge clk);
            sat_clr = 1'b0;
            push(vecs[k].sum);
            chk($sformatf("v%0d_sat", k), 32'(sat_flag), 32'(vecs[k].sat));
            chk($sformatf("v%0d_level", k), 32'(fifo_level), 32'd1);
            en = 1'b1;
            @(negedge clk);
            en = 1'b0;
            capture_bits(32, 0);
            chk($sformatf("v%0d_frame", k), frame_sd(0), {vecs[k].word, 16'h0000});
            chk($sformatf("v%0d_ws", k), frame_ws(0), 32'h0000FFFF);
            repeat (12) @(negedge clk);
            chk($sformatf("v%0d_idle_sclk", k), 32'(sclk), 32'd0);
        end

        // sat_clr coincident with a saturating write: set wins
        sat_clr   = 1'b1;
        sum_in    = 23'h3FFFFF;
        sum_valid = 1'b1;
        @(negedge clk);
        sat_clr   = 1'b0;
        sum_valid = 1'b0;
        chk("sat_set_wins", 32'(sat_flag), 32'd1);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        chk("sat_clr_clears", 32'(sat_flag), 32'd0);
        do_reset(1);
        chk("rst1_level", 32'(fifo_level), 32'd0);

        // full FIFO: 6 offered, 4 taken
        en        = 1'b0;
        accepted  = 0;
        sum_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sum_in = 23'((k + 1) * 128);
            if (in_ready) accepted++;
            @(negedge clk);
        end
        sum_valid = 1'b0;
        chk("full_accepted", 32'(accepted), 32'd4);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        en = 1'b1;
        @(negedge clk);
        chk("first_pop_level", 32'(fifo_level), 32'd3);
        chk("first_pop_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            capture_bits(32, 0);
            chk($sformatf("order_w%0d", k + 1), frame_sd(0), {16'(k + 1), 16'h0000});
        end
        capture_bits(1, 0);
        en = 1'b0;
        capture_bits(31, 1);
        chk("order_w4", frame_sd(0), {16'h0004, 16'h0000});
        repeat (12) @(negedge clk);
        chk("drain_level", 32'(fifo_level), 32'd0);
        chk("drain_idle_sclk", 32'(sclk), 32'd0);
        chk("drain_no_underrun", 32'(underrun), 32'd0);

        // underrun and frame length
        en = 1'b1;
        push(23'h000040);
        capture_bits(32, 0);
        chk("ur_frame1", frame_sd(0), {16'h0001, 16'h0000});
        chk("ur_flag_before", 32'(underrun), 32'd0);
        capture_bits(32, 32);
        en = 1'b0;
        chk("ur_frame2_zero", frame_sd(32), 32'h0);
        chk("ur_frame2_ws", frame_ws(32), 32'h0000FFFF);
        chk("bit_period", 32'(rise_cyc[1] - rise_cyc[0]), 32'd8);
        chk("frame_period", 32'(rise_cyc[32] - rise_cyc[0]), 32'd256);
        chk("ur_flag", 32'(underrun), 32'd1);
        repeat (12) @(negedge clk);
        chk("ur_idle_sclk", 32'(sclk), 32'd0);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        chk("ur_clear", 32'(underrun), 32'd0);

        // disable mid-frame: frame completes, remaining words kept
        push(23'h000400);
        push(23'h000480);
        push(23'h000500);
        en = 1'b1;
        capture_bits(5, 0);
        en = 1'b0;
        capture_bits(27, 5);
        chk("dis_frame", frame_sd(0), {16'h0008, 16'h0000});
        chk("dis_ws", frame_ws(0), 32'h0000FFFF);
        repeat (12) @(negedge clk);
        count_rises(40, rises);
        chk("dis_no_sclk", 32'(rises), 32'd0);
        chk("dis_sclk_low", 32'(sclk), 32'd0);
        chk("dis_ws_low", 32'(ws), 32'd0);
        chk("dis_level_kept", 32'(fifo_level), 32'd2);
        en = 1'b1;
        capture_bits(32, 0);
        chk("dis_resume_word", frame_sd(0), {16'h0009, 16'h0000});

        // reset in the middle of the next frame
        capture_bits(6, 0);
        push(23'h3FFFFF);
        chk("mid_sat_set", 32'(sat_flag), 32'd1);
        do_reset(3);
        chk_reset_state("rst_mid");
        count_rises(30, rises);
        chk("rst_mid_stays_idle", 32'(rises), 32'd0);
        en = 1'b0;

        chk("sd_ws_stable_while_sclk_high", 32'(glitches), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/beam_pcm_serializer.md
Name: beam_pcm_serializer

Overview:
- Downstream consumer of the 16-channel beamformer adder tree.
- Takes the signed 23-bit beam sum and rounds, shifts and saturates it to a PCM word.
- Buffers the words in a small FIFO.
- Streams them out as a left-justified, I2S-style serial frame toward the codec/host interface. It generates its own bit clock and word select from the system clock.

Parameters:
IN_W, 23, width of incoming beam sum (signed two's complement)
OUT_W, 16, PCM word width (signed)
SHIFT, 7, arithmetic right shift applied before saturation (must be >=1)
FIFO_DEPTH, 4, PCM word buffer depth (power of 2)
BCLK_DIV, 4, clk cycles per sclk half-period

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sum_in  in  IN_W  beam sum from adder tree, signed
sum_valid  in  1  sum_in valid
in_ready  out  1  FIFO can accept; transfer when sum_valid & in_ready
en  in  1  serializer enable
sat_clr  in  1  clear sticky sat_flag/underrun
sclk  out  1  serial bit clock
ws  out  1  word select: 0 = left slot, 1 = right slot
sd  out  1  serial data, MSB first
sat_flag  out  1  sticky: a saturation occurred
underrun  out  1  sticky: frame started with FIFO empty
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, active-high; applies at any point, including mid-frame):
  - clears FIFO, all counters and the shift register; state = IDLE.
  - outputs: sclk=0, ws=0, sd=0, sat_flag=0, underrun=0, fifo_level=0, in_ready=1 in the following cycle.
- Conversion (combinational on the write path):
  - v = sign-extend(sum_in) to IN_W+1 bits, plus 2^(SHIFT-1).
  - v is arithmetic-shifted right by SHIFT.
  - Result is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - A clamp on an accepted write sets sat_flag.
- FIFO:
  - in_ready = (fifo_level != FIFO_DEPTH), computed from registered occupancy only.
  - A write is refused when the FIFO is full, even if a pop happens in the same cycle.
  - An accepted word is poppable in the next cycle.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags:
  - sat_clr clears sat_flag and underrun.
  - If a set event and sat_clr occur in the same cycle, set wins.
- Bit timing:
  - div_cnt counts 0..BCLK_DIV-1 while the state is not IDLE.
  - At terminal count sclk toggles.
  - The falling toggle (1->0) is bit_tick.
  - Bit period = 2*BCLK_DIV clk cycles; frame = 2*OUT_W bits = 256 clk cycles at defaults.
- State machine IDLE / SLOT_L / SLOT_R:
  - IDLE: sclk=0, ws=0, sd=0. When en=1 and FIFO is non-empty:
    - pop into shift register; sd = word MSB, ws=0;
    - bit_cnt = OUT_W-1, div_cnt=0, go to SLOT_L.
  - SLOT_L: on each bit_tick, shift left and present the next bit on sd.
    - After OUT_W bits: ws=1, sd=0, go to SLOT_R.
  - SLOT_R: sd held 0 for OUT_W bits.
    - At the last bit_tick, if en=0: go to IDLE (sclk/ws/sd return to 0).
    - Otherwise, if the FIFO is non-empty: pop and go to SLOT_L.
    - Otherwise: load 0, set underrun, go to SLOT_L.
- en deasserted mid-frame: the current frame always completes; the block stops only at a frame boundary.
- sd and ws change only coincident with the sclk falling edge, or on the IDLE exit cycle.

Test Plan:
1. Reset:
   - Assert rst 3 cycles mid-frame -> next cycle sclk=ws=sd=0, fifo_level=0, in_ready=1, flags 0, state IDLE.
2. Rounding:
   - en=1, push 0x000040 -> left slot serializes 0x0001 MSB first, then 16 zero bits with ws=1; frame length 256 clk.
   - Push 0x00003F -> word 0x0000.
3. Saturation:
   - Push 0x3FFFFF -> word 0x7FFF, sat_flag=1.
   - Push 0x400000 -> word 0x8000, no new saturation.
   - sat_clr -> sat_flag=0.
   - sat_clr in the same cycle as a saturating write -> sat_flag=1.
4. Full FIFO:
   - en=0, hold sum_valid 6 cycles -> 4 words accepted, in_ready=0 with fifo_level=4.
   - Enable -> words emitted in order, in_ready=1 after first pop.
5. Underrun:
   - en=1, push one word, then nothing -> second frame left slot all zeros, underrun=1, sclk continues uninterrupted.
6. Disable mid-frame:
   - Drop en at bit 5 of SLOT_L -> frame finishes (remaining L bits + full R slot), then IDLE with sclk=0.
   - Remaining FIFO words retained.
